// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_ctrl_reg.sv
// Enabled register with synchronous active-low clear.
module mem_ctrl_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles; o_expire marks the cycle the count reaches LIMIT.
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_busy,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_busy) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds completed BUSY cycles, so LIMIT-1 means this is the LIMIT-th
    assign o_expire = i_busy && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller for a multi-cycle data memory.
// Optional BUSY timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_en,
    input  logic        in_mem_wr,
    input  logic [15:0] in_addr,
    input  logic [15:0] in_wr_data,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_done,
    input  logic [15:0] dmem_rdata,
    output logic        stall_up,
    output logic        out_valid,
    output logic [15:0] out_rd_data,
    output logic        err
);

    state_t   r_state;
    state_t   w_next;
    logic     r_err;
    logic     w_err_set;
    logic     w_cap_en;
    logic     w_rd_en;
    logic     w_expire;
    logic [15:0] w_rd_d;
    logic [15:0] w_rd_q;
    mem_req_t w_cap_d;
    mem_req_t w_cap_q;

    assign w_cap_d = '{wr: in_mem_wr, addr: in_addr, wdata: in_wr_data};

    mem_ctrl_reg #(.W($bits(mem_req_t))) u_cap (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_cap_en),
        .i_d  (w_cap_d),
        .o_q  (w_cap_q)
    );

    mem_ctrl_reg #(.W(16)) u_rd (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_rd_en),
        .i_d  (w_rd_d),
        .o_q  (w_rd_q)
    );

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_to (
        .clk      (clk),
        .rst      (rst),
        .i_busy   (r_state == BUSY),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_next    = r_state;
        stall_up  = 1'b0;
        out_valid = 1'b0;
        dmem_req  = 1'b0;
        w_cap_en  = 1'b0;
        w_rd_en   = 1'b0;
        w_rd_d    = 16'h0000;
        w_err_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !in_mem_en) begin
                    out_valid = 1'b1;
                end else if (in_valid && in_addr[0]) begin
                    out_valid = 1'b1;
                    w_err_set = 1'b1;
                end else if (in_valid) begin
                    stall_up = 1'b1;
                    w_cap_en = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                dmem_req = 1'b1;
                stall_up = 1'b1;
                // a completion on the expiry cycle is still a normal finish
                if (dmem_done) begin
                    w_rd_en = 1'b1;
                    w_rd_d  = w_cap_q.wr ? 16'h0000 : dmem_rdata;
                    w_next  = DONE;
                end else if (w_expire) begin
                    w_rd_en   = 1'b1;
                    w_err_set = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign dmem_wr     = w_cap_q.wr;
    assign dmem_addr   = w_cap_q.addr;
    assign dmem_wdata  = w_cap_q.wdata;
    assign out_rd_data = (r_state == DONE) ? w_rd_q : 16'h0000;
    assign err         = r_err;

endmodule
